// File: rtl/scan_ctrl_pkg.sv
// Shared types for the configuration scan-chain loader.
// Holds the controller state encoding and the serial bit-order flag.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Bit 0 of every configuration word leaves the serializer first.
  localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/scan_chain_loader_if.sv
// Valid/ready word port between the bitstream source and the scan-chain loader.
// The source drives data and valid; the loader answers with ready.
interface scan_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/scan_word_serializer.sv
// Parallel-in/serial-out word register for the scan write path.
// Loads a word with a bit budget and reports when the last budgeted bit is on the output.
module scan_word_serializer
  import scan_ctrl_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BW     = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] din,
  input  logic [BW-1:0]     nbits,
  output logic              bit_out,
  output logic              last_bit
);

  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bits_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bits_left <= '0;
    end else if (load) begin
      shreg     <= din;
      bits_left <= nbits;
    end else if (shift) begin
      if (LSB_FIRST) begin
        shreg <= {1'b0, shreg[WORD_W-1:1]};
      end else begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
      end
      if (bits_left != '0) begin
        bits_left <= bits_left - BW'(1);
      end
    end
  end

  assign bit_out  = LSB_FIRST ? shreg[0] : shreg[WORD_W-1];
  // Terminal count: the bit currently presented is the last one used from this word.
  assign last_bit = (bits_left == BW'(1));

endmodule

// File: rtl/scan_chain_loader.sv
// Loads the fabric configuration scan chain from a word stream, exactly CHAIN_LEN shifts per load.
// Optional macro SCAN_READBACK_EN adds capture of the old chain contents from scan_out (rd_data/rd_valid).
//
// state | meaning
// IDLE  | waiting for start; all outputs low
// LOAD  | in_ready high, waiting for the next configuration word
// SHIFT | one bit per cycle onto scan_in with scan_en/scan_wen high
// DONE  | single-cycle done pulse, then back to IDLE
module scan_chain_loader
  import scan_ctrl_pkg::*;
#(
  parameter  int CHAIN_LEN = 1024,
  parameter  int WORD_W    = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  scan_chain_loader_if.slave  cfg,
  output logic                scan_in,
  output logic                scan_en,
  output logic                scan_wen,
  input  logic                scan_out,
  output logic                busy,
  output logic                done
`ifdef SCAN_READBACK_EN
  ,
  output logic [WORD_W-1:0]   rd_data,
  output logic                rd_valid
`endif
);

  localparam int BW = $clog2(WORD_W + 1);

  scan_state_e      state, state_nxt;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] bits_remaining;
  logic [BW-1:0]    word_bits;
  logic             ready;
  logic             ser_load;
  logic             ser_shift;
  logic             ser_bit;
  logic             ser_last;
  logic             total_clr;
  logic             final_shift;

  // The last word may only use what is left of the chain; its upper bits are dropped.
  assign bits_remaining = CNT_W'(CHAIN_LEN) - total_cnt;
  assign word_bits      = (32'(bits_remaining) >= WORD_W) ? BW'(WORD_W) : BW'(bits_remaining);
  assign final_shift    = ser_shift && ser_last && (total_cnt == CNT_W'(CHAIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    scan_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    total_clr = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          total_clr = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (cfg.in_valid) begin
          ser_load  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        scan_en   = 1'b1;
        busy      = 1'b1;
        ser_shift = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (final_shift) begin
          state_nxt = DONE;
        end else if (ser_last) begin
          state_nxt = LOAD;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      total_cnt <= '0;
    end else if (total_clr) begin
      total_cnt <= '0;
    end else if (ser_shift) begin
      total_cnt <= total_cnt + CNT_W'(1);
    end
  end

  scan_word_serializer #(
    .WORD_W (WORD_W),
    .BW     (BW)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (ser_load),
    .shift    (ser_shift),
    .din      (cfg.in_data),
    .nbits    (word_bits),
    .bit_out  (ser_bit),
    .last_bit (ser_last)
  );

  assign cfg.in_ready = ready;
  assign scan_in      = (state == SHIFT) && ser_bit;
  assign scan_wen     = scan_en;

`ifdef SCAN_READBACK_EN
  localparam int RB_W = $clog2(WORD_W);

  logic [RB_W-1:0]   rb_cnt;
  logic [WORD_W-1:0] rb_word;
  logic [WORD_W-1:0] rb_word_nxt;

  always_comb begin
    rb_word_nxt         = rb_word;
    rb_word_nxt[rb_cnt] = scan_out;
  end

  // Tail bits arrive oldest-first; a short final word leaves its upper bits zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_cnt   <= '0;
      rb_word  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (total_clr) begin
        rb_cnt  <= '0;
        rb_word <= '0;
      end else if (ser_shift) begin
        if ((rb_cnt == RB_W'(WORD_W - 1)) || final_shift) begin
          rd_data  <= rb_word_nxt;
          rd_valid <= 1'b1;
          rb_cnt   <= '0;
          rb_word  <= '0;
        end else begin
          rb_word <= rb_word_nxt;
          rb_cnt  <= rb_cnt + RB_W'(1);
        end
      end
    end
  end
`else
  logic unused_scan_out;
  assign unused_scan_out = scan_out;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader with a 40-flop chain model and 32-bit words.
// Build with SCAN_READBACK_EN defined to also exercise the readback outputs.
module tb_scan_chain_loader;

  localparam int CHAIN_LEN = 40;
  localparam int WORD_W    = 32;
  localparam logic [31:0] W0 = 32'hA5A5_A5A5;
  localparam logic [31:0] W1 = 32'h0000_00C3;
  localparam logic [39:0] EXP_CHAIN = 40'hC3_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic scan_in, scan_en, scan_wen, scan_out, busy, done;

  scan_chain_loader_if #(.WORD_W(WORD_W)) cfg_if ();

`ifdef SCAN_READBACK_EN
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_q[$];
`endif

  scan_chain_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cfg      (cfg_if),
    .scan_in  (scan_in),
    .scan_en  (scan_en),
    .scan_wen (scan_wen),
    .scan_out (scan_out),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_READBACK_EN
    ,
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: chain[0] is the tail (farthest from the head), chain[39] the head.
  logic [39:0] chain;
  logic        preload_req = 1'b0;
  logic [39:0] preload_val = '0;
  int          wen_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scan_wen) wen_cnt <= wen_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (preload_req) chain <= preload_val;
    else if (scan_wen) chain <= {scan_in, chain[39:1]};
  end

  assign scan_out = chain[0];

`ifdef SCAN_READBACK_EN
  always @(negedge clk) begin
    if (rd_valid) rd_q.push_back(rd_data);
  end
`endif

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [39:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output int acc_cyc);
    int n;
    n = 0;
    while (!cfg_if.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_val("ready_timeout", 0, 1);
    repeat (gap) @(negedge clk);
    if (gap > 0) check_val("gap_hold", {scan_wen, scan_en, cfg_if.in_ready, busy}, 4'b0011);
    cfg_if.in_data  = w;
    cfg_if.in_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    cfg_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc);
    int n;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_val("done_timeout", 0, 1);
    done_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic full_load(input int gap, output int acc_cyc, output int done_cyc);
    int tmp;
    start_load();
    send_word(W0, 0, acc_cyc);
    send_word(W1, gap, tmp);
    wait_done(done_cyc);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dn, b_wen, b_done, tmp;
`ifdef SCAN_READBACK_EN
    int b_rd;
`endif
    cfg_if.in_data  = '0;
    cfg_if.in_valid = 1'b0;

    // Reset
    preload(40'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_outs", {cfg_if.in_ready, scan_in, scan_en, scan_wen, busy, done}, 6'b0);

    // Full load, zero stall
    b_wen  = wen_cnt;
    b_done = done_cnt;
    start_load();
    check_val("load_state", {busy, cfg_if.in_ready, scan_wen}, 3'b110);
    send_word(W0, 0, acc);
    check_val("first_shift", {scan_wen, scan_en, scan_in, cfg_if.in_ready}, 4'b1110);
    send_word(W1, 0, tmp);
    wait_done(dn);
    check_val("wen_count", wen_cnt - b_wen, 40);
    check_val("done_count", done_cnt - b_done, 1);
    check_val("done_latency", dn - acc, 42);
    check_val("chain_nostall", chain, EXP_CHAIN);
    check_val("idle_after_done", {busy, done, scan_en}, 3'b0);

    // Gap of 5 cycles before the second word
    preload(40'h0);
    b_wen  = wen_cnt;
    b_done = done_cnt;
    full_load(5, acc, dn);
    check_val("gap_wen_count", wen_cnt - b_wen, 40);
    check_val("gap_done_count", done_cnt - b_done, 1);
    check_val("gap_latency", dn - acc, 47);
    check_val("chain_gap", chain, EXP_CHAIN);

    // Abort during the 10th shift
    preload(40'h0);
    b_wen  = wen_cnt;
    b_done = done_cnt;
    start_load();
    send_word(W0, 0, acc);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_outs", {scan_en, scan_wen, busy, cfg_if.in_ready}, 4'b0);
    check_val("abort_wen_count", wen_cnt - b_wen, 10);
    check_val("abort_chain", chain, 40'h69_4000_0000);
    repeat (50) @(negedge clk);
    check_val("abort_no_done", done_cnt - b_done, 0);
    b_wen = wen_cnt;
    full_load(0, acc, dn);
    check_val("post_abort_chain", chain, EXP_CHAIN);
    check_val("post_abort_wen", wen_cnt - b_wen, 40);

    // start during SHIFT ignored
    preload(40'h0);
    b_wen  = wen_cnt;
    b_done = done_cnt;
    start_load();
    send_word(W0, 0, acc);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("start_in_shift", {scan_wen, busy}, 2'b11);
    send_word(W1, 0, tmp);
    wait_done(dn);
    check_val("start_shift_wen", wen_cnt - b_wen, 40);
    check_val("start_shift_chain", chain, EXP_CHAIN);
    check_val("start_shift_latency", dn - acc, 42);

    // start together with abort in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("start_abort_idle", {busy, cfg_if.in_ready, scan_en}, 3'b0);

    // Reset in the middle of SHIFT
    preload(40'h0);
    start_load();
    send_word(W0, 0, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_outs", {cfg_if.in_ready, scan_in, scan_en, scan_wen, busy, done}, 6'b0);
    repeat (4) @(negedge clk);
    check_val("rst_ready_low", cfg_if.in_ready, 1'b0);
    full_load(0, acc, dn);
    check_val("post_rst_chain", chain, EXP_CHAIN);

`ifdef SCAN_READBACK_EN
    // Readback of the old chain contents
    preload(40'h12_3456_789A);
    b_rd = rd_q.size();
    full_load(0, acc, dn);
    check_val("rd_count", rd_q.size() - b_rd, 2);
    if (rd_q.size() >= b_rd + 2) begin
      check_val("rd_word0", rd_q[b_rd], 32'h3456_789A);
      check_val("rd_word1", rd_q[b_rd+1], 32'h0000_0012);
    end
    check_val("rd_chain", chain, EXP_CHAIN);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
